// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if
// Memory bus between the memory-access stage and the data memory.
// One request is outstanding at a time; the stage holds mem_req and the
// address/write fields steady until the memory answers with mem_ack.
//   mem_req   : request outstanding (stage -> memory)
//   mem_we    : 1 = write, 0 = read (stage -> memory)
//   mem_addr  : 8-byte aligned byte address (stage -> memory)
//   mem_wdata : store data (stage -> memory)
//   mem_ack   : completion; read data valid in the same cycle (memory -> stage)
//   mem_rdata : load data (memory -> stage)
interface mem_access_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage
// Memory-access pipeline stage. ALU results pass straight through to
// writeback one cycle after they arrive. 64-bit loads/stores are issued on
// the memory bus and stall execute until the memory acknowledges.
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   EXMEM_ready         : execute presents a valid instruction
//   exmm_aluresult      : ALU result, or effective address for memory ops
//   dest_reg            : destination register (0 = no writeback)
//   mem_active, load    : memory op select, load (1) / store (0)
//   ex_store_data       : store data
//   bus                 : memory bus (master side)
//   MEMEX_stall         : execute must hold while 1
//   MEMEX_rd/_rdval     : forwarding copy of the registered writeback
//   wb_valid/_rd/_rdval : writeback, one pulse per retired instruction
//   stall_cycles        : saturating count of stalled cycles
module mem_access_stage (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        EXMEM_ready,
    input  logic [63:0]                 exmm_aluresult,
    input  logic [5:0]                  dest_reg,
    input  logic                        mem_active,
    input  logic                        load,
    input  logic [63:0]                 ex_store_data,
    mem_access_stage_if.master          bus,
    output logic                        MEMEX_stall,
    output logic [5:0]                  MEMEX_rd,
    output logic [63:0]                 MEMEX_rdval,
    output logic                        wb_valid,
    output logic [5:0]                  wb_rd,
    output logic [63:0]                 wb_rdval,
    output logic [31:0]                 stall_cycles
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [5:0]  rd_q, rd_d;
    logic        wb_valid_q, wb_valid_d;
    logic [5:0]  wb_rd_q, wb_rd_d;
    logic [63:0] wb_rdval_q, wb_rdval_d;
    logic [31:0] stall_count_q;

    // Next-state and next-output logic. The writeback registers default to
    // zero so any cycle without a retirement forwards x0.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = 6'd0;
        wb_rdval_d = 64'd0;
        case (state_q)
            IDLE: begin
                if (EXMEM_ready) begin
                    if (mem_active) begin
                        addr_d  = {exmm_aluresult[63:3], 3'b000};
                        wdata_d = ex_store_data;
                        we_d    = ~load;
                        rd_d    = dest_reg;
                        state_d = BUSY;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = dest_reg;
                        wb_rdval_d = exmm_aluresult;
                    end
                end
            end
            BUSY: begin
                // Stores retire with no register writeback.
                if (bus.mem_ack) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    if (!we_q) begin
                        wb_rd_d    = rd_q;
                        wb_rdval_d = bus.mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            addr_q        <= 64'd0;
            wdata_q       <= 64'd0;
            we_q          <= 1'b0;
            rd_q          <= 6'd0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= 6'd0;
            wb_rdval_q    <= 64'd0;
            stall_count_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_rdval_q <= wb_rdval_d;
            // Saturates instead of wrapping so long stalls never read as short.
            if (state_q == BUSY && stall_count_q != 32'hFFFF_FFFF) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign MEMEX_stall   = (state_q == BUSY);
    assign bus.mem_req   = (state_q == BUSY);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    // Forwarding uses the registered writeback, never the raw bus data.
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_rdval     = wb_rdval_q;
    assign MEMEX_rd     = wb_rd_q;
    assign MEMEX_rdval  = wb_rdval_q;
    assign stall_cycles = stall_count_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
// Self-checking bench for mem_access_stage: directed scenarios plus a
// randomized instruction stream checked against an instruction-level model
// (expected retirement list and total stalled cycles).
module tb_mem_access_stage;

    logic        clk;
    logic        reset;
    logic        EXMEM_ready;
    logic [63:0] exmm_aluresult;
    logic [5:0]  dest_reg;
    logic        mem_active;
    logic        load;
    logic [63:0] ex_store_data;
    logic        MEMEX_stall;
    logic [5:0]  MEMEX_rd;
    logic [63:0] MEMEX_rdval;
    logic        wb_valid;
    logic [5:0]  wb_rd;
    logic [63:0] wb_rdval;
    logic [31:0] stall_cycles;

    mem_access_stage_if bus();

    int          pass_cnt;
    int          total_cnt;
    logic [31:0] exp_stall;

    typedef struct {
        bit          is_mem;
        bit          is_load;
        logic [5:0]  rd;
        logic [63:0] alu;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          delay;
    } instr_t;

    mem_access_stage dut (
        .clk            (clk),
        .reset          (reset),
        .EXMEM_ready    (EXMEM_ready),
        .exmm_aluresult (exmm_aluresult),
        .dest_reg       (dest_reg),
        .mem_active     (mem_active),
        .load           (load),
        .ex_store_data  (ex_store_data),
        .bus            (bus),
        .MEMEX_stall    (MEMEX_stall),
        .MEMEX_rd       (MEMEX_rd),
        .MEMEX_rdval    (MEMEX_rdval),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_rdval       (wb_rdval),
        .stall_cycles   (stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task tick;
        @(posedge clk);
        #1;
    endtask

    task drive_ex(input logic rdy, input logic act, input logic ld,
                  input logic [5:0] rd, input logic [63:0] alu, input logic [63:0] sd);
        EXMEM_ready    = rdy;
        mem_active     = act;
        load           = ld;
        dest_reg       = rd;
        exmm_aluresult = alu;
        ex_store_data  = sd;
    endtask

    function automatic logic [31:0] sat_add(input logic [31:0] a, input int b);
        longint s;
        s = longint'({32'd0, a}) + longint'(b);
        return (s > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
    endfunction

    task test_reset;
        reset = 1'b0;
        drive_ex(1'b1, 1'b1, 1'b1, 6'd33, {$urandom, $urandom}, {$urandom, $urandom});
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = {$urandom, $urandom};
        tick;
        tick;
        total_cnt++; if (wb_valid !== 1'b0) $display("[TB] FAIL reset_wb_valid got %h exp %h", wb_valid, 1'b0); else pass_cnt++;
        total_cnt++; if (wb_rd !== 6'd0) $display("[TB] FAIL reset_wb_rd got %h exp %h", wb_rd, 6'd0); else pass_cnt++;
        total_cnt++; if (wb_rdval !== 64'd0) $display("[TB] FAIL reset_wb_rdval got %h exp %h", wb_rdval, 64'd0); else pass_cnt++;
        total_cnt++; if (bus.mem_req !== 1'b0) $display("[TB] FAIL reset_mem_req got %h exp %h", bus.mem_req, 1'b0); else pass_cnt++;
        total_cnt++; if (bus.mem_we !== 1'b0) $display("[TB] FAIL reset_mem_we got %h exp %h", bus.mem_we, 1'b0); else pass_cnt++;
        total_cnt++; if (bus.mem_addr !== 64'd0) $display("[TB] FAIL reset_mem_addr got %h exp %h", bus.mem_addr, 64'd0); else pass_cnt++;
        total_cnt++; if (bus.mem_wdata !== 64'd0) $display("[TB] FAIL reset_mem_wdata got %h exp %h", bus.mem_wdata, 64'd0); else pass_cnt++;
        total_cnt++; if (MEMEX_stall !== 1'b0) $display("[TB] FAIL reset_stall got %h exp %h", MEMEX_stall, 1'b0); else pass_cnt++;
        total_cnt++; if (stall_cycles !== 32'd0) $display("[TB] FAIL reset_stall_cycles got %h exp %h", stall_cycles, 32'd0); else pass_cnt++;
        reset       = 1'b1;
        bus.mem_ack = 1'b0;
        drive_ex(1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 64'd0);
        exp_stall = 32'd0;
        tick;
    endtask

    task test_alu;
        drive_ex(1'b1, 1'b0, 1'b0, 6'd5, 64'h1234, {$urandom, $urandom});
        tick;
        total_cnt++; if (wb_valid !== 1'b1) $display("[TB] FAIL alu_wb_valid got %h exp %h", wb_valid, 1'b1); else pass_cnt++;
        total_cnt++; if (wb_rd !== 6'd5) $display("[TB] FAIL alu_wb_rd got %h exp %h", wb_rd, 6'd5); else pass_cnt++;
        total_cnt++; if (wb_rdval !== 64'h1234) $display("[TB] FAIL alu_wb_rdval got %h exp %h", wb_rdval, 64'h1234); else pass_cnt++;
        total_cnt++; if (MEMEX_rd !== 6'd5) $display("[TB] FAIL alu_fwd_rd got %h exp %h", MEMEX_rd, 6'd5); else pass_cnt++;
        total_cnt++; if (MEMEX_rdval !== 64'h1234) $display("[TB] FAIL alu_fwd_rdval got %h exp %h", MEMEX_rdval, 64'h1234); else pass_cnt++;
        total_cnt++; if (MEMEX_stall !== 1'b0) $display("[TB] FAIL alu_stall got %h exp %h", MEMEX_stall, 1'b0); else pass_cnt++;
        total_cnt++; if (bus.mem_req !== 1'b0) $display("[TB] FAIL alu_mem_req got %h exp %h", bus.mem_req, 1'b0); else pass_cnt++;
        // Bubble: writeback clears so the forwarding index becomes x0.
        drive_ex(1'b0, 1'b0, 1'b0, 6'd17, {$urandom, $urandom}, 64'd0);
        tick;
        total_cnt++; if (wb_valid !== 1'b0) $display("[TB] FAIL bubble_wb_valid got %h exp %h", wb_valid, 1'b0); else pass_cnt++;
        total_cnt++; if (MEMEX_rd !== 6'd0) $display("[TB] FAIL bubble_fwd_rd got %h exp %h", MEMEX_rd, 6'd0); else pass_cnt++;
        total_cnt++; if (wb_rdval !== 64'd0) $display("[TB] FAIL bubble_wb_rdval got %h exp %h", wb_rdval, 64'd0); else pass_cnt++;
    endtask

    task test_load;
        drive_ex(1'b1, 1'b1, 1'b1, 6'd7, 64'h100F, {$urandom, $urandom});
        bus.mem_ack = 1'b0;
        tick;
        total_cnt++; if (wb_valid !== 1'b0) $display("[TB] FAIL load_accept_wb_valid got %h exp %h", wb_valid, 1'b0); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if (bus.mem_req !== 1'b1) $display("[TB] FAIL load_mem_req got %h exp %h", bus.mem_req, 1'b1); else pass_cnt++;
            total_cnt++; if (bus.mem_addr !== 64'h1008) $display("[TB] FAIL load_mem_addr got %h exp %h", bus.mem_addr, 64'h1008); else pass_cnt++;
            total_cnt++; if (bus.mem_we !== 1'b0) $display("[TB] FAIL load_mem_we got %h exp %h", bus.mem_we, 1'b0); else pass_cnt++;
            total_cnt++; if (MEMEX_stall !== 1'b1) $display("[TB] FAIL load_stall got %h exp %h", MEMEX_stall, 1'b1); else pass_cnt++;
            // Execute inputs while busy must be ignored.
            drive_ex(1'b1, $urandom_range(0, 1) == 1, 1'b0, 6'($urandom_range(0, 63)), {$urandom, $urandom}, {$urandom, $urandom});
            bus.mem_ack   = (i == 2);
            bus.mem_rdata = (i == 2) ? 64'hDEAD : {$urandom, $urandom};
            tick;
        end
        bus.mem_ack = 1'b0;
        drive_ex(1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 64'd0);
        exp_stall = sat_add(exp_stall, 3);
        total_cnt++; if (wb_valid !== 1'b1) $display("[TB] FAIL load_wb_valid got %h exp %h", wb_valid, 1'b1); else pass_cnt++;
        total_cnt++; if (wb_rd !== 6'd7) $display("[TB] FAIL load_wb_rd got %h exp %h", wb_rd, 6'd7); else pass_cnt++;
        total_cnt++; if (wb_rdval !== 64'hDEAD) $display("[TB] FAIL load_wb_rdval got %h exp %h", wb_rdval, 64'hDEAD); else pass_cnt++;
        total_cnt++; if (MEMEX_stall !== 1'b0) $display("[TB] FAIL load_done_stall got %h exp %h", MEMEX_stall, 1'b0); else pass_cnt++;
        total_cnt++; if (stall_cycles !== 32'd3) $display("[TB] FAIL load_stall_cycles got %h exp %h", stall_cycles, 32'd3); else pass_cnt++;
    endtask

    task test_store;
        drive_ex(1'b1, 1'b1, 1'b0, 6'd12, 64'h20, 64'hAA);
        bus.mem_ack = 1'b0;
        tick;
        total_cnt++; if (bus.mem_req !== 1'b1) $display("[TB] FAIL store_mem_req got %h exp %h", bus.mem_req, 1'b1); else pass_cnt++;
        total_cnt++; if (bus.mem_we !== 1'b1) $display("[TB] FAIL store_mem_we got %h exp %h", bus.mem_we, 1'b1); else pass_cnt++;
        total_cnt++; if (bus.mem_wdata !== 64'hAA) $display("[TB] FAIL store_mem_wdata got %h exp %h", bus.mem_wdata, 64'hAA); else pass_cnt++;
        total_cnt++; if (bus.mem_addr !== 64'h20) $display("[TB] FAIL store_mem_addr got %h exp %h", bus.mem_addr, 64'h20); else pass_cnt++;
        drive_ex(1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 64'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = {$urandom, $urandom};
        tick;
        bus.mem_ack = 1'b0;
        exp_stall = sat_add(exp_stall, 1);
        total_cnt++; if (wb_valid !== 1'b1) $display("[TB] FAIL store_wb_valid got %h exp %h", wb_valid, 1'b1); else pass_cnt++;
        total_cnt++; if (wb_rd !== 6'd0) $display("[TB] FAIL store_wb_rd got %h exp %h", wb_rd, 6'd0); else pass_cnt++;
        total_cnt++; if (wb_rdval !== 64'd0) $display("[TB] FAIL store_wb_rdval got %h exp %h", wb_rdval, 64'd0); else pass_cnt++;
        total_cnt++; if (bus.mem_req !== 1'b0) $display("[TB] FAIL store_done_mem_req got %h exp %h", bus.mem_req, 1'b0); else pass_cnt++;
    endtask

    task test_ack_idle;
        drive_ex(1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 64'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = {$urandom, $urandom};
        tick;
        tick;
        bus.mem_ack = 1'b0;
        total_cnt++; if (wb_valid !== 1'b0) $display("[TB] FAIL idle_ack_wb_valid got %h exp %h", wb_valid, 1'b0); else pass_cnt++;
        total_cnt++; if (MEMEX_stall !== 1'b0) $display("[TB] FAIL idle_ack_stall got %h exp %h", MEMEX_stall, 1'b0); else pass_cnt++;
        total_cnt++; if (stall_cycles !== exp_stall) $display("[TB] FAIL idle_ack_stall_cycles got %h exp %h", stall_cycles, exp_stall); else pass_cnt++;
    endtask

    task test_back_to_back;
        // ALU op, then load, then ALU op held by execute while stalled.
        drive_ex(1'b1, 1'b0, 1'b0, 6'd3, 64'h1111, 64'd0);
        tick;
        total_cnt++; if (wb_valid !== 1'b1 || wb_rd !== 6'd3 || wb_rdval !== 64'h1111) $display("[TB] FAIL b2b_alu1 got %h/%h/%h exp 1/03/1111", wb_valid, wb_rd, wb_rdval); else pass_cnt++;
        drive_ex(1'b1, 1'b1, 1'b1, 6'd4, 64'h2000, 64'd0);
        tick;
        total_cnt++; if (wb_valid !== 1'b0 || MEMEX_stall !== 1'b1) $display("[TB] FAIL b2b_accept got valid %h stall %h exp 0/1", wb_valid, MEMEX_stall); else pass_cnt++;
        drive_ex(1'b1, 1'b0, 1'b0, 6'd9, 64'h9999, 64'd0);
        tick;
        total_cnt++; if (wb_valid !== 1'b0 || MEMEX_stall !== 1'b1) $display("[TB] FAIL b2b_busy got valid %h stall %h exp 0/1", wb_valid, MEMEX_stall); else pass_cnt++;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 64'h4444;
        tick;
        bus.mem_ack = 1'b0;
        total_cnt++; if (wb_valid !== 1'b1 || wb_rd !== 6'd4 || wb_rdval !== 64'h4444) $display("[TB] FAIL b2b_load got %h/%h/%h exp 1/04/4444", wb_valid, wb_rd, wb_rdval); else pass_cnt++;
        tick;
        total_cnt++; if (wb_valid !== 1'b1 || wb_rd !== 6'd9 || wb_rdval !== 64'h9999) $display("[TB] FAIL b2b_alu2 got %h/%h/%h exp 1/09/9999", wb_valid, wb_rd, wb_rdval); else pass_cnt++;
        drive_ex(1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 64'd0);
        tick;
        total_cnt++; if (wb_valid !== 1'b0) $display("[TB] FAIL b2b_no_dup got %h exp %h", wb_valid, 1'b0); else pass_cnt++;
        exp_stall = sat_add(exp_stall, 2);
        total_cnt++; if (stall_cycles !== exp_stall) $display("[TB] FAIL b2b_stall_cycles got %h exp %h", stall_cycles, exp_stall); else pass_cnt++;
    endtask

    task test_random;
        instr_t      prog[$];
        instr_t      ins;
        logic [5:0]  exp_rd[$];
        logic [63:0] exp_val[$];
        logic [5:0]  obs_rd[$];
        logic [63:0] obs_val[$];
        int          n;
        int          ptr;
        int          mem_idx;
        int          wait_cnt;
        int          cycles;
        int          busy_total;
        bit          rdy;
        bit          accept;
        n = 16; ptr = 0; mem_idx = 0; wait_cnt = 0; cycles = 0; busy_total = 0;
        for (int i = 0; i < n; i++) begin
            ins.is_mem  = ($urandom_range(0, 2) != 0);
            ins.is_load = ($urandom_range(0, 1) == 1);
            ins.rd      = 6'($urandom_range(0, 63));
            ins.alu     = {$urandom, $urandom};
            ins.wdata   = {$urandom, $urandom};
            ins.rdata   = {$urandom, $urandom};
            ins.delay   = $urandom_range(0, 4);
            prog.push_back(ins);
            if (!ins.is_mem) begin
                exp_rd.push_back(ins.rd); exp_val.push_back(ins.alu);
            end else begin
                busy_total += ins.delay + 1;
                if (ins.is_load) begin exp_rd.push_back(ins.rd); exp_val.push_back(ins.rdata); end
                else begin exp_rd.push_back(6'd0); exp_val.push_back(64'd0); end
            end
        end
        while ((ptr < n || MEMEX_stall === 1'b1) && cycles < 2000) begin
            rdy = (ptr < n) && ($urandom_range(0, 3) != 0);
            if (ptr < n) drive_ex(rdy, prog[ptr].is_mem, prog[ptr].is_load, prog[ptr].rd, prog[ptr].alu, prog[ptr].wdata);
            else drive_ex(1'b0, 1'b1, 1'b1, 6'd1, {$urandom, $urandom}, 64'd0);
            if (bus.mem_req === 1'b1) begin
                if (wait_cnt == 0) begin
                    total_cnt++; if (bus.mem_addr !== {prog[mem_idx].alu[63:3], 3'b000}) $display("[TB] FAIL rnd_mem_addr got %h exp %h", bus.mem_addr, {prog[mem_idx].alu[63:3], 3'b000}); else pass_cnt++;
                    total_cnt++; if (bus.mem_we !== !prog[mem_idx].is_load) $display("[TB] FAIL rnd_mem_we got %h exp %h", bus.mem_we, !prog[mem_idx].is_load); else pass_cnt++;
                    if (!prog[mem_idx].is_load) begin
                        total_cnt++; if (bus.mem_wdata !== prog[mem_idx].wdata) $display("[TB] FAIL rnd_mem_wdata got %h exp %h", bus.mem_wdata, prog[mem_idx].wdata); else pass_cnt++;
                    end
                end
                bus.mem_ack   = (wait_cnt == prog[mem_idx].delay);
                bus.mem_rdata = bus.mem_ack ? prog[mem_idx].rdata : {$urandom, $urandom};
                wait_cnt++;
            end else begin
                bus.mem_ack   = ($urandom_range(0, 1) == 1);
                bus.mem_rdata = {$urandom, $urandom};
            end
            accept = rdy && (MEMEX_stall === 1'b0);
            tick;
            cycles++;
            if (accept) begin
                if (prog[ptr].is_mem) begin mem_idx = ptr; wait_cnt = 0; end
                ptr++;
            end
            if (wb_valid === 1'b1) begin obs_rd.push_back(wb_rd); obs_val.push_back(wb_rdval); end
        end
        bus.mem_ack = 1'b0;
        drive_ex(1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 64'd0);
        total_cnt++; if (cycles >= 2000) $display("[TB] FAIL rnd_timeout got %0d cycles exp below %0d", cycles, 2000); else pass_cnt++;
        total_cnt++; if (obs_rd.size() != exp_rd.size()) $display("[TB] FAIL rnd_retire_count got %0d exp %0d", obs_rd.size(), exp_rd.size()); else pass_cnt++;
        for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++) begin
            total_cnt++; if (obs_rd[i] !== exp_rd[i] || obs_val[i] !== exp_val[i]) $display("[TB] FAIL rnd_retire_%0d got %h/%h exp %h/%h", i, obs_rd[i], obs_val[i], exp_rd[i], exp_val[i]); else pass_cnt++;
        end
        exp_stall = sat_add(exp_stall, busy_total);
        total_cnt++; if (stall_cycles !== exp_stall) $display("[TB] FAIL rnd_stall_cycles got %h exp %h", stall_cycles, exp_stall); else pass_cnt++;
    endtask

    task test_reset_busy;
        drive_ex(1'b1, 1'b1, 1'b1, 6'd11, 64'h3000, 64'd0);
        bus.mem_ack = 1'b0;
        tick;
        drive_ex(1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 64'd0);
        total_cnt++; if (MEMEX_stall !== 1'b1) $display("[TB] FAIL rstbusy_enter got %h exp %h", MEMEX_stall, 1'b1); else pass_cnt++;
        // Reset wins even with an ack on the same edge.
        reset         = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 64'h5555;
        tick;
        reset = 1'b1;
        exp_stall = 32'd0;
        total_cnt++; if (bus.mem_req !== 1'b0) $display("[TB] FAIL rstbusy_mem_req got %h exp %h", bus.mem_req, 1'b0); else pass_cnt++;
        total_cnt++; if (wb_valid !== 1'b0) $display("[TB] FAIL rstbusy_wb_valid got %h exp %h", wb_valid, 1'b0); else pass_cnt++;
        total_cnt++; if (stall_cycles !== 32'd0) $display("[TB] FAIL rstbusy_stall_cycles got %h exp %h", stall_cycles, 32'd0); else pass_cnt++;
        tick;
        bus.mem_ack = 1'b0;
        total_cnt++; if (wb_valid !== 1'b0) $display("[TB] FAIL rstbusy_late_ack got %h exp %h", wb_valid, 1'b0); else pass_cnt++;
        total_cnt++; if (MEMEX_stall !== 1'b0) $display("[TB] FAIL rstbusy_stall got %h exp %h", MEMEX_stall, 1'b0); else pass_cnt++;
    endtask

    task test_saturation;
        drive_ex(1'b1, 1'b1, 1'b1, 6'd2, 64'h40, 64'd0);
        bus.mem_ack = 1'b0;
        tick;
        drive_ex(1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 64'd0);
        force dut.stall_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_count_q;
        for (int i = 0; i < 3; i++) begin
            tick;
            total_cnt++; if (stall_cycles !== 32'hFFFF_FFFF) $display("[TB] FAIL sat_hold_%0d got %h exp %h", i, stall_cycles, 32'hFFFF_FFFF); else pass_cnt++;
        end
        bus.mem_ack = 1'b1;
        tick;
        bus.mem_ack = 1'b0;
        total_cnt++; if (wb_valid !== 1'b1 || wb_rd !== 6'd2) $display("[TB] FAIL sat_retire got %h/%h exp 1/02", wb_valid, wb_rd); else pass_cnt++;
        tick;
        total_cnt++; if (stall_cycles !== 32'hFFFF_FFFF) $display("[TB] FAIL sat_idle got %h exp %h", stall_cycles, 32'hFFFF_FFFF); else pass_cnt++;
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        exp_stall     = 32'd0;
        reset         = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 64'd0;
        drive_ex(1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 64'd0);
        test_reset;
        test_alu;
        test_load;
        test_store;
        test_ack_idle;
        test_back_to_back;
        test_random;
        test_reset_busy;
        test_saturation;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
